// File: rtl/apb_timer_multi_pkg.sv
// Shared constants and types for the multi-channel APB timer.
// Optional feature macro: TIMER_CASCADE_EN (see timer_channel / apb_timer_multi).
package apb_timer_multi_pkg;

  // Register offsets within a channel window (PADDR[3:2])
  localparam logic [1:0] REG_TIMER  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_ONESHOT   = 1;
  localparam int unsigned CTRL_IE_OVF    = 2;
  localparam int unsigned CTRL_IE_CMP    = 3;
  localparam int unsigned CTRL_CASCADE   = 4;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STS_OVF = 0;
  localparam int unsigned STS_CMP = 1;

  // Widest supported prescaler field; narrower builds mask the upper bits to 0
  localparam int unsigned PRESC_MAX_WIDTH = 16;

  // CTRL register image, laid out exactly as it reads back on the bus
  typedef struct packed {
    logic [7:0]                 rsvd_hi;
    logic [PRESC_MAX_WIDTH-1:0] presc;
    logic [2:0]                 rsvd_lo;
    logic                       cascade;
    logic                       ie_cmp;
    logic                       ie_ovf;
    logic                       oneshot;
    logic                       en;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: TIMER/CTRL/CMP/STATUS registers, prescaler and event logic.
// Optional feature macro: TIMER_CASCADE_EN (stores CTRL.CASCADE when HasCascade).
module timer_channel
  import apb_timer_multi_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned PRESC_WIDTH = 8,
  parameter bit          HasCascade  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_timer_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_cmp_i,
  input  logic        wr_status_i,
  input  logic [31:0] wdata_i,
  input  logic        cas_tick_i,
  output logic [31:0] timer_o,
  output logic [31:0] ctrl_o,
  output logic [31:0] cmp_o,
  output logic [31:0] status_o,
  output logic        evt_o,
  output logic        irq_o
);

  localparam logic [PRESC_MAX_WIDTH-1:0] PrescMask =
    PRESC_MAX_WIDTH'((32'd1 << PRESC_WIDTH) - 32'd1);

`ifdef TIMER_CASCADE_EN
  localparam bit CascadeImpl = HasCascade;
`else
  localparam bit CascadeImpl = HasCascade & 1'b0;
`endif

  logic [CNT_WIDTH-1:0]       timer_q, timer_d, cmp_q, cmp_d;
  logic [PRESC_MAX_WIDTH-1:0] pcnt_q, pcnt_d;
  ctrl_t                      ctrl_q, ctrl_d, ctrl_wr;
  logic                       sts_ovf_q, sts_ovf_d, sts_cmp_q, sts_cmp_d;
  logic                       presc_hit, tick, cmp_hit, ovf_hit, en_rise;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // Decode the bus word into a CTRL image; unimplemented bits stay 0
  always_comb begin
    ctrl_wr         = '0;
    ctrl_wr.en      = wdata_i[CTRL_EN];
    ctrl_wr.oneshot = wdata_i[CTRL_ONESHOT];
    ctrl_wr.ie_ovf  = wdata_i[CTRL_IE_OVF];
    ctrl_wr.ie_cmp  = wdata_i[CTRL_IE_CMP];
    ctrl_wr.cascade = CascadeImpl & wdata_i[CTRL_CASCADE];
    ctrl_wr.presc   = wdata_i[CTRL_PRESC_LSB +: PRESC_MAX_WIDTH] & PrescMask;
  end

  // Tick source and event detection
  always_comb begin
    // >= so a PRESC lowered below a running pcnt still ticks promptly
    presc_hit = (pcnt_q >= ctrl_q.presc);
    tick      = ctrl_q.en & (ctrl_q.cascade ? cas_tick_i : presc_hit);
    cmp_hit   = tick & (cmp_q != '0) & (timer_q == cmp_q);
    ovf_hit   = tick & ~cmp_hit & (timer_q == '1);
    en_rise   = wr_ctrl_i & ctrl_wr.en & ~ctrl_q.en;
  end

  // Next-state: bus writes override the tick-driven update
  always_comb begin
    timer_d = timer_q;
    if (tick) timer_d = (cmp_hit | ovf_hit) ? '0 : timer_q + CNT_WIDTH'(1);
    if (wr_timer_i) timer_d = wdata_i[CNT_WIDTH-1:0];
    if (wr_cmp_i) timer_d = '0;

    cmp_d = wr_cmp_i ? wdata_i[CNT_WIDTH-1:0] : cmp_q;

    pcnt_d = pcnt_q;
    if (ctrl_q.en & ~ctrl_q.cascade) pcnt_d = presc_hit ? '0 : pcnt_q + PRESC_MAX_WIDTH'(1);
    if (wr_cmp_i | en_rise) pcnt_d = '0;

    ctrl_d = ctrl_q;
    if ((cmp_hit | ovf_hit) & ctrl_q.oneshot) ctrl_d.en = 1'b0;
    if (wr_ctrl_i) ctrl_d = ctrl_wr;

    // W1C, but a same-cycle event keeps the bit set
    sts_ovf_d = (sts_ovf_q & ~(wr_status_i & wdata_i[STS_OVF])) | ovf_hit;
    sts_cmp_d = (sts_cmp_q & ~(wr_status_i & wdata_i[STS_CMP])) | cmp_hit;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q   <= '0;
      cmp_q     <= '0;
      pcnt_q    <= '0;
      ctrl_q    <= '0;
      sts_ovf_q <= 1'b0;
      sts_cmp_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      pcnt_q    <= pcnt_d;
      ctrl_q    <= ctrl_d;
      sts_ovf_q <= sts_ovf_d;
      sts_cmp_q <= sts_cmp_d;
    end
  end

  // Register read images, event pulse and level interrupt
  always_comb begin
    timer_o           = 32'(timer_q);
    ctrl_o            = ctrl_q;
    cmp_o             = 32'(cmp_q);
    status_o          = '0;
    status_o[STS_OVF] = sts_ovf_q;
    status_o[STS_CMP] = sts_cmp_q;
    evt_o             = cmp_hit | ovf_hit;
    irq_o             = (sts_ovf_q & ctrl_q.ie_ovf) | (sts_cmp_q & ctrl_q.ie_cmp);
  end

endmodule

// File: rtl/apb_timer_multi.sv
// Multi-channel APB timer: APB decode, read mux, PSLVERR and channel array.
// Optional feature macro: TIMER_CASCADE_EN (chains channel i-1 events into channel i).
module apb_timer_multi
  import apb_timer_multi_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned N_TIMERS       = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned PRESC_WIDTH    = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [N_TIMERS-1:0]       irq_o
);

  logic [31:0]         addr_ext;
  logic [3:0]          ch_idx;
  logic [1:0]          reg_idx;
  logic                in_range, access, wr_en;
  logic [31:0]         rd_mux;
  logic [N_TIMERS-1:0] evt, cas_tick;
  logic [31:0]         timer_rd [N_TIMERS];
  logic [31:0]         ctrl_rd  [N_TIMERS];
  logic [31:0]         cmp_rd   [N_TIMERS];
  logic [31:0]         sts_rd   [N_TIMERS];

  logic unused_sig;
  assign unused_sig = ^{addr_ext, evt};

  // Address decode; anything outside the populated channel windows is an error
  always_comb begin
    addr_ext = 32'(PADDR);
    ch_idx   = addr_ext[7:4];
    reg_idx  = addr_ext[3:2];
    in_range = (addr_ext[11:8] == 4'd0) && (32'(ch_idx) < N_TIMERS);
    access   = PSEL & PENABLE;
    wr_en    = access & PWRITE & in_range;
  end

  for (genvar i = 0; i < N_TIMERS; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_en & (ch_idx == 4'(i));

`ifdef TIMER_CASCADE_EN
    if (i == 0) begin : g_head
      assign cas_tick[i] = 1'b0;
    end else begin : g_link
      assign cas_tick[i] = evt[i-1];
    end
`else
    assign cas_tick[i] = 1'b0;
`endif

    timer_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .PRESC_WIDTH(PRESC_WIDTH),
      .HasCascade (i > 0)
    ) u_ch (
      .clk_i      (HCLK),
      .rst_i      (HRESET),
      .wr_timer_i (wr_sel & (reg_idx == REG_TIMER)),
      .wr_ctrl_i  (wr_sel & (reg_idx == REG_CTRL)),
      .wr_cmp_i   (wr_sel & (reg_idx == REG_CMP)),
      .wr_status_i(wr_sel & (reg_idx == REG_STATUS)),
      .wdata_i    (PWDATA),
      .cas_tick_i (cas_tick[i]),
      .timer_o    (timer_rd[i]),
      .ctrl_o     (ctrl_rd[i]),
      .cmp_o      (cmp_rd[i]),
      .status_o   (sts_rd[i]),
      .evt_o      (evt[i]),
      .irq_o      (irq_o[i])
    );
  end

  // Combinational read mux, driven only during a valid read access phase
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (ch_idx == 4'(i)) begin
        unique case (reg_idx)
          REG_TIMER: rd_mux = timer_rd[i];
          REG_CTRL:  rd_mux = ctrl_rd[i];
          REG_CMP:   rd_mux = cmp_rd[i];
          default:   rd_mux = sts_rd[i];
        endcase
      end
    end
    PRDATA  = (access & ~PWRITE & in_range) ? rd_mux : 32'd0;
    PSLVERR = access & ~in_range;
    PREADY  = 1'b1;
  end

endmodule

// File: tb/tb_apb_timer_multi.sv
// Directed bench for apb_timer_multi (default parameters, N_TIMERS = 4).
// Cascade checks are compiled in when TIMER_CASCADE_EN is defined.
module tb_apb_timer_multi;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [3:0]  irq_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        wr_err;

  apb_timer_multi #(
    .APB_ADDR_WIDTH(12),
    .N_TIMERS      (4),
    .CNT_WIDTH     (32),
    .PRESC_WIDTH   (8)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .irq_o  (irq_o)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [11:0] addr_of(input int ch, input int r);
    return 12'(ch * 16 + r * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
  endtask

  // Reads are combinational, so a bare access phase within one half-cycle suffices
  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    e = PSLVERR;
    idle();
  endtask

  task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    rd(a, d, e);
    chk(tag, d, exp);
  endtask

  // Called just after a negedge; commits on the second following posedge and
  // returns at the negedge right after that commit.
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 wr_err = PSLVERR;
    @(negedge HCLK);
    idle();
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    idle();
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;

    // Reset state
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        chk_rd($sformatf("rst ch%0d r%0d", c, r), addr_of(c, r), 32'h0);
    chk("rst irq", 32'(irq_o), 32'h0);
    chk("pready", 32'(PREADY), 32'h1);
    chk("idle pslverr", 32'(PSLVERR), 32'h0);

    // ch1: compare match at 5, auto-reload, PRESC = 0
    wr(addr_of(1, 2), 32'd5);
    wr(addr_of(1, 1), 32'h9);
    chk("ch1 wr pslverr", 32'(wr_err), 32'h0);
    for (int k = 0; k <= 5; k++) begin
      chk_rd($sformatf("ch1 count %0d", k), addr_of(1, 0), 32'(k));
      chk_rd($sformatf("ch1 sts pre %0d", k), addr_of(1, 3), 32'h0);
      @(negedge HCLK);
    end
    chk_rd("ch1 wrapped", addr_of(1, 0), 32'h0);
    chk_rd("ch1 sts cmp", addr_of(1, 3), 32'h2);
    chk("ch1 irq set", 32'(irq_o), 32'h2);
    wr(addr_of(1, 3), 32'h2);
    chk_rd("ch1 sts w1c", addr_of(1, 3), 32'h0);
    chk("ch1 irq clr", 32'(irq_o), 32'h0);
    wr(addr_of(1, 1), 32'h0);
    chk_rd("ch1 stopped", addr_of(1, 0), 32'd4);

    // ch0: PRESC = 3, CMP = 2, one-shot
    wr(addr_of(0, 2), 32'd2);
    wr(addr_of(0, 1), 32'h303);
    chk_rd("ch0 start", addr_of(0, 0), 32'h0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge HCLK);
      chk_rd($sformatf("ch0 presc n%0d", n), addr_of(0, 0), (n < 12) ? 32'(n / 4) : 32'h0);
    end
    chk_rd("ch0 oneshot ctrl", addr_of(0, 1), 32'h302);
    chk_rd("ch0 sts", addr_of(0, 3), 32'h2);
    chk("ch0 no irq", 32'(irq_o), 32'h0);
    repeat (8) @(negedge HCLK);
    chk_rd("ch0 held", addr_of(0, 0), 32'h0);

    // ch2: overflow from 0xFFFF_FFFE
    wr(addr_of(2, 0), 32'hFFFF_FFFE);
    wr(addr_of(2, 1), 32'h5);
    chk_rd("ch2 load", addr_of(2, 0), 32'hFFFF_FFFE);
    @(negedge HCLK);
    chk_rd("ch2 max", addr_of(2, 0), 32'hFFFF_FFFF);
    chk_rd("ch2 sts pre", addr_of(2, 3), 32'h0);
    @(negedge HCLK);
    chk_rd("ch2 ovf wrap", addr_of(2, 0), 32'h0);
    chk_rd("ch2 sts ovf", addr_of(2, 3), 32'h1);
    chk("ch2 irq", 32'(irq_o), 32'h4);
    wr(addr_of(2, 1), 32'h0);
    wr(addr_of(2, 3), 32'h1);
    chk_rd("ch2 sts clr", addr_of(2, 3), 32'h0);

    // W1C lands on the same edge as a fresh overflow: set wins
    wr(addr_of(2, 0), 32'hFFFF_FFFE);
    wr(addr_of(2, 1), 32'h5);
    wr(addr_of(2, 3), 32'h1);
    chk_rd("w1c collide sts", addr_of(2, 3), 32'h1);
    chk_rd("w1c collide tmr", addr_of(2, 0), 32'h0);
    chk("w1c collide irq", 32'(irq_o), 32'h4);
    wr(addr_of(2, 1), 32'h0);
    wr(addr_of(2, 3), 32'h1);
    chk_rd("ch2 sts final", addr_of(2, 3), 32'h0);
    chk("ch2 irq final", 32'(irq_o), 32'h0);

    // Out-of-range channel and upper address bits
    rd(12'h050, d, e);
    chk("oor rd data", d, 32'h0);
    chk("oor rd err", 32'(e), 32'h1);
    wr(12'h054, 32'h1);
    chk("oor wr err", 32'(wr_err), 32'h1);
    wr(12'h050, 32'h1234);
    chk_rd("oor alias ctrl", addr_of(1, 1), 32'h0);
    chk_rd("oor alias tmr", addr_of(1, 0), 32'd4);
    rd(12'h104, d, e);
    chk("hi rd data", d, 32'h0);
    chk("hi rd err", 32'(e), 32'h1);
    wr(12'h108, 32'd7);
    chk("hi wr err", 32'(wr_err), 32'h1);
    chk_rd("hi alias cmp", addr_of(0, 2), 32'd2);
    rd(addr_of(0, 1), d, e);
    chk("valid rd err", 32'(e), 32'h0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr_of(0, 1);
    #1 chk("setup prdata", PRDATA, 32'h0);
    idle();

    // ch3: TIMER write beats a same-cycle tick
    wr(addr_of(3, 1), 32'h1);
    wr(addr_of(3, 0), 32'd100);
    chk_rd("wr prio", addr_of(3, 0), 32'd100);
    @(negedge HCLK);
    chk_rd("wr prio next", addr_of(3, 0), 32'd101);

`ifdef TIMER_CASCADE_EN
    wr(addr_of(1, 2), 32'h0);
    wr(addr_of(1, 1), 32'h11);
    chk_rd("cas ch1 ctrl", addr_of(1, 1), 32'h11);
    wr(addr_of(0, 2), 32'd1);
    wr(addr_of(0, 1), 32'h11);
    chk_rd("cas ch0 ctrl", addr_of(0, 1), 32'h01);
    chk_rd("cas ch1 t0", addr_of(1, 0), 32'h0);
    repeat (4) @(negedge HCLK);
    chk_rd("cas ch1 t4", addr_of(1, 0), 32'd2);
    repeat (6) @(negedge HCLK);
    chk_rd("cas ch1 t10", addr_of(1, 0), 32'd5);
`else
    wr(addr_of(1, 1), 32'h10);
    chk_rd("nocas ch1 ctrl", addr_of(1, 1), 32'h0);
    wr(addr_of(0, 1), 32'h11);
    chk_rd("nocas ch0 ctrl", addr_of(0, 1), 32'h01);
`endif

    // Reset in the middle of counting
    HRESET = 1'b1;
    @(negedge HCLK);
    chk_rd("mid rst ch3 tmr", addr_of(3, 0), 32'h0);
    chk_rd("mid rst ch3 ctrl", addr_of(3, 1), 32'h0);
    chk_rd("mid rst ch0 cmp", addr_of(0, 2), 32'h0);
    chk_rd("mid rst ch0 sts", addr_of(0, 3), 32'h0);
    chk("mid rst irq", 32'(irq_o), 32'h0);
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    chk_rd("post rst ch3", addr_of(3, 0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
